// File: rtl/dphy_pkg.sv
// Shared definitions for the D-PHY HS lane sequencer: FSM state encoding,
// the HS sync byte and the LP line codes.
package dphy_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line codes, packed as {Dp, Dn}
    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_00 = 2'b00;

    typedef enum logic [2:0] {
        ST_STOP     = 3'd0,
        ST_HS_RQST  = 3'd1,
        ST_HS_PREP  = 3'd2,
        ST_HS_ZERO  = 3'd3,
        ST_HS_SYNC  = 3'd4,
        ST_HS_DATA  = 3'd5,
        ST_HS_TRAIL = 3'd6,
        ST_HS_EXIT  = 3'd7
    } dphy_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dphy_lane_trail.sv
// Per-lane HS byte holder: keeps the last byte sent on the lane, switches to
// the trail byte on request and times the lane's minimum trail length.
module dphy_lane_trail
    import dphy_pkg::*;
#(
    parameter int unsigned T_HS_TRAIL = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       set_en_i,
    input  logic [7:0] set_byte_i,
    input  logic       load_en_i,
    input  logic [7:0] load_byte_i,
    input  logic       trail_start_i,
    output logic [7:0] byte_o,
    output logic       done_o
);

    localparam int unsigned CNT_W = $clog2(T_HS_TRAIL + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(T_HS_TRAIL - 1);

    logic [7:0]       byte_q, byte_d;
    logic             trailing_q, trailing_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Forced bytes win; once trailing, the trail byte is held until the next force.
    always_comb begin
        byte_d     = byte_q;
        trailing_d = trailing_q;
        cnt_d      = cnt_q;
        if (set_en_i) begin
            byte_d     = set_byte_i;
            trailing_d = 1'b0;
            cnt_d      = '0;
        end else if (trailing_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (trail_start_i) begin
            trailing_d = 1'b1;
            cnt_d      = CNT_LOAD;
            byte_d     = {8{~byte_q[7]}};
        end else if (load_en_i) begin
            byte_d = load_byte_i;
        end
        done_d = trailing_d && (cnt_d == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_q     <= '0;
            trailing_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            byte_q     <= byte_d;
            trailing_q <= trailing_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign byte_o = byte_q;
    assign done_o = done_q;

endmodule

// File: rtl/dphy_hs_lane_sequencer.sv
// N-lane D-PHY HS burst sequencer in the byte clock domain: LP-11 -> LP-01 ->
// LP-00 -> HS-0 -> SYNC -> DATA -> TRAIL -> LP-11 on all data lanes together.
module dphy_hs_lane_sequencer
    import dphy_pkg::*;
#(
    parameter int unsigned NUM_LANES    = 2,
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 2,
    parameter int unsigned T_HS_ZERO    = 6,
    parameter int unsigned T_HS_TRAIL   = 3,
    parameter int unsigned T_HS_EXIT    = 3
) (
    input  logic                   TxByteClkHS,
    input  logic                   TxRst,
    input  logic                   TxRequestHS,
    input  logic                   TxValidHS,
    input  logic [NUM_LANES-1:0]   TxWordValidHS,
    input  logic [8*NUM_LANES-1:0] TxDataHS,
    output logic                   TxReadyHS,
    output logic [NUM_LANES-1:0]   TxHsEnable,
    output logic [8*NUM_LANES-1:0] TxHsData,
    output logic [NUM_LANES-1:0]   TxLpDp,
    output logic [NUM_LANES-1:0]   TxLpDn,
    output logic                   TxClk_Enable,
    output logic                   TxStopState,
    output logic                   TxErrUnderflow,
    output logic [2:0]             DphyTxState
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_LPX, T_HS_PREPARE),
                                                max_u(T_HS_ZERO, T_HS_TRAIL)), T_HS_EXIT);
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam logic [CNT_W-1:0] LPX_LOAD  = CNT_W'(T_LPX - 1);
    localparam logic [CNT_W-1:0] PREP_LOAD = CNT_W'(T_HS_PREPARE - 1);
    localparam logic [CNT_W-1:0] ZERO_LOAD = CNT_W'(T_HS_ZERO - 1);
    localparam logic [CNT_W-1:0] EXIT_LOAD = CNT_W'(T_HS_EXIT - 1);

    if (NUM_LANES < 1 || NUM_LANES > 4) begin : g_bad_lanes
        $error("dphy_hs_lane_sequencer: NUM_LANES must be 1..4");
    end
    if (T_LPX < 1 || T_HS_PREPARE < 1 || T_HS_ZERO < 1 || T_HS_TRAIL < 1 || T_HS_EXIT < 1)
    begin : g_bad_timing
        $error("dphy_hs_lane_sequencer: all T_* parameters must be >= 1");
    end

    dphy_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_seen_q, last_seen_d;
    logic                 ready_q, ready_d;
    logic                 underflow_q, underflow_d;
    logic                 clk_en_q, clk_en_d;
    logic                 stop_q, stop_d;
    logic [NUM_LANES-1:0] hs_en_q, hs_en_d;
    logic [NUM_LANES-1:0] lp_dp_q, lp_dp_d;
    logic [NUM_LANES-1:0] lp_dn_q, lp_dn_d;
    logic [1:0]           lp_code;

    logic                 accept;
    logic                 full_word;
    logic                 cnt_zero;
    logic [NUM_LANES-1:0] partial_trail;
    logic                 lane_set_en;
    logic [7:0]           lane_set_byte;
    logic [NUM_LANES-1:0] lane_load_en;
    logic [NUM_LANES-1:0] lane_trail_start;
    logic [NUM_LANES-1:0] lane_done;

    assign accept    = (state_q == ST_HS_DATA) && TxValidHS && ready_q;
    assign full_word = &TxWordValidHS;
    assign cnt_zero  = (cnt_q == '0);

    // Next-state: a word taken while the request drops is treated as the final word.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_seen_d   = last_seen_q;
        underflow_d   = underflow_q;
        lane_load_en  = '0;
        partial_trail = '0;
        case (state_q)
            ST_STOP: begin
                if (TxRequestHS) begin
                    state_d = ST_HS_RQST;
                    cnt_d   = LPX_LOAD;
                end
            end
            ST_HS_RQST: begin
                if (cnt_zero) begin
                    state_d = ST_HS_PREP;
                    cnt_d   = PREP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HS_PREP: begin
                if (cnt_zero) begin
                    state_d = ST_HS_ZERO;
                    cnt_d   = ZERO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HS_ZERO: begin
                if (cnt_zero) begin
                    state_d = ST_HS_SYNC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HS_SYNC: begin
                last_seen_d = 1'b0;
                state_d     = TxRequestHS ? ST_HS_DATA : ST_HS_TRAIL;
            end
            ST_HS_DATA: begin
                if (accept) begin
                    lane_load_en = TxWordValidHS;
                    if (!full_word || !TxRequestHS) begin
                        last_seen_d   = 1'b1;
                        partial_trail = ~TxWordValidHS;
                    end
                end else if (last_seen_q || !TxRequestHS) begin
                    state_d = ST_HS_TRAIL;
                end else if (!TxValidHS) begin
                    underflow_d = 1'b1;
                end
            end
            ST_HS_TRAIL: begin
                if (&lane_done) begin
                    state_d = ST_HS_EXIT;
                    cnt_d   = EXIT_LOAD;
                end
            end
            ST_HS_EXIT: begin
                if (cnt_zero) begin
                    state_d = TxRequestHS ? ST_HS_RQST : ST_STOP;
                    cnt_d   = LPX_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Output decode from the next state so registered outputs line up with DphyTxState.
    always_comb begin
        lp_code          = LP_00;
        hs_en_d          = '0;
        lane_set_en      = 1'b1;
        lane_set_byte    = 8'h00;
        lane_trail_start = '0;
        case (state_d)
            ST_STOP, ST_HS_EXIT: lp_code = LP_11;
            ST_HS_RQST:          lp_code = LP_01;
            ST_HS_ZERO:          hs_en_d = '1;
            ST_HS_SYNC: begin
                hs_en_d       = '1;
                lane_set_byte = SYNC_BYTE;
            end
            ST_HS_DATA: begin
                hs_en_d          = '1;
                lane_set_en      = 1'b0;
                lane_trail_start = partial_trail;
            end
            ST_HS_TRAIL: begin
                hs_en_d          = '1;
                lane_set_en      = 1'b0;
                lane_trail_start = '1;
            end
            default: lp_code = LP_00;
        endcase
        lp_dp_d  = {NUM_LANES{lp_code[1]}};
        lp_dn_d  = {NUM_LANES{lp_code[0]}};
        clk_en_d = (state_d != ST_STOP);
        stop_d   = (state_d == ST_STOP);
        ready_d  = (state_d == ST_HS_DATA) && TxRequestHS && !last_seen_d;
    end

    always_ff @(posedge TxByteClkHS) begin
        if (TxRst) begin
            state_q     <= ST_STOP;
            cnt_q       <= '0;
            last_seen_q <= 1'b0;
            ready_q     <= 1'b0;
            underflow_q <= 1'b0;
            clk_en_q    <= 1'b0;
            stop_q      <= 1'b1;
            hs_en_q     <= '0;
            lp_dp_q     <= '1;
            lp_dn_q     <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_seen_q <= last_seen_d;
            ready_q     <= ready_d;
            underflow_q <= underflow_d;
            clk_en_q    <= clk_en_d;
            stop_q      <= stop_d;
            hs_en_q     <= hs_en_d;
            lp_dp_q     <= lp_dp_d;
            lp_dn_q     <= lp_dn_d;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        dphy_lane_trail #(
            .T_HS_TRAIL(T_HS_TRAIL)
        ) u_lane (
            .clk_i         (TxByteClkHS),
            .rst_i         (TxRst),
            .set_en_i      (lane_set_en),
            .set_byte_i    (lane_set_byte),
            .load_en_i     (lane_load_en[k]),
            .load_byte_i   (TxDataHS[8*k +: 8]),
            .trail_start_i (lane_trail_start[k]),
            .byte_o        (TxHsData[8*k +: 8]),
            .done_o        (lane_done[k])
        );
    end

    assign TxReadyHS      = ready_q;
    assign TxHsEnable     = hs_en_q;
    assign TxLpDp         = lp_dp_q;
    assign TxLpDn         = lp_dn_q;
    assign TxClk_Enable   = clk_en_q;
    assign TxStopState    = stop_q;
    assign TxErrUnderflow = underflow_q;
    assign DphyTxState    = state_q;

endmodule
